// File: rtl/i2c_ddc_slave_ctrl_if.sv
// rtl/i2c_ddc_slave_ctrl_if.sv - byte/edge handshake bundle between DDC bus side and slave controller
interface i2c_ddc_slave_ctrl_if;
  logic [1:0] sda_edge_buf;
  logic [1:0] scl_edge_buf;
  logic [7:0] tx_data;
  logic       wr_ack_en;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       tx_req;
  logic       bus_start;
  logic       bus_stop;
  logic       busy;

  modport master (
    output sda_edge_buf, scl_edge_buf, tx_data, wr_ack_en,
    input  sda_oe, rx_data, rx_valid, rx_first, tx_req, bus_start, bus_stop, busy
  );

  modport slave (
    input  sda_edge_buf, scl_edge_buf, tx_data, wr_ack_en,
    output sda_oe, rx_data, rx_valid, rx_first, tx_req, bus_start, bus_stop, busy
  );
endinterface

// File: rtl/i2c_ddc_slave_ctrl.sv
// rtl/i2c_ddc_slave_ctrl.sv - I2C slave protocol sequencer for the DDC/EDID channel
module i2c_ddc_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_ddc_slave_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  // In the ACK states: 0 = waiting for the fall that opens the ninth clock,
  // 1 = waiting for the fall that closes it. In RD_ACK: 1 = master ACKed.
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       tx_req_q, tx_req_d;
  logic       bus_start_q, bus_start_d;
  logic       bus_stop_q, bus_stop_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev, sda_bit;
  logic [7:0] shift_in;

  assign scl_rise = (bus.scl_edge_buf == 2'b01);
  assign scl_fall = (bus.scl_edge_buf == 2'b10);
  assign start_ev = (bus.scl_edge_buf == 2'b11) && (bus.sda_edge_buf == 2'b10);
  assign stop_ev  = (bus.scl_edge_buf == 2'b11) && (bus.sda_edge_buf == 2'b01);
  assign sda_bit  = bus.sda_edge_buf[0];
  assign shift_in = {rx_shift_q, sda_bit};

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      rx_shift_q  <= 7'd0;
      tx_shift_q  <= 7'd0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      bus_start_q <= 1'b0;
      bus_stop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      tx_req_q    <= tx_req_d;
      bus_start_q <= bus_start_d;
      bus_stop_q  <= bus_stop_d;
    end
  end

  // Next-state: bus conditions first, then per-state bit sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rw_d        = rw_q;
    first_d     = first_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    tx_req_d    = 1'b0;
    bus_start_d = 1'b0;
    bus_stop_d  = 1'b0;

    if (start_ev) begin
      state_d     = S_ADDR;
      cnt_d       = 3'd0;
      phase_d     = 1'b0;
      sda_oe_d    = 1'b0;
      bus_start_d = 1'b1;
    end else if (stop_ev) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      bus_stop_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise) begin
            rx_shift_d = shift_in[6:0];
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              phase_d = 1'b0;
              if (shift_in[7:1] == SLAVE_ADDR) begin
                rw_d    = shift_in[0];
                state_d = S_ADDR_ACK;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
              tx_req_d = rw_q;
            end else begin
              phase_d = 1'b0;
              cnt_d   = 3'd0;
              if (rw_q) begin
                tx_shift_d = bus.tx_data[6:0];
                sda_oe_d   = ~bus.tx_data[7];
                state_d    = S_RD_DATA;
              end else begin
                sda_oe_d = 1'b0;
                first_d  = 1'b1;
                state_d  = S_WR_DATA;
              end
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise) begin
            rx_shift_d = shift_in[6:0];
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              phase_d    = 1'b0;
              state_d    = S_WR_ACK;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = bus.wr_ack_en;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_WR_DATA;
            end
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_bit) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_IGNORE;
            end
          end else if (scl_fall && phase_q) begin
            tx_shift_d = bus.tx_data[6:0];
            sda_oe_d   = ~bus.tx_data[7];
            cnt_d      = 3'd0;
            phase_d    = 1'b0;
            state_d    = S_RD_DATA;
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs come straight from registers; busy decodes the addressed states
  always_comb begin
    bus.sda_oe    = sda_oe_q;
    bus.rx_data   = rx_data_q;
    bus.rx_valid  = rx_valid_q;
    bus.rx_first  = rx_first_q;
    bus.tx_req    = tx_req_q;
    bus.bus_start = bus_start_q;
    bus.bus_stop  = bus_stop_q;
    bus.busy      = (state_q == S_ADDR_ACK) || (state_q == S_WR_DATA) ||
                    (state_q == S_WR_ACK)   || (state_q == S_RD_DATA) ||
                    (state_q == S_RD_ACK);
  end

endmodule

// File: tb/tb_i2c_ddc_slave_ctrl.sv
// tb/tb_i2c_ddc_slave_ctrl.sv - scoreboard bench for the DDC I2C slave controller
module tb_i2c_ddc_slave_ctrl;
  localparam logic [6:0] ADDR = 7'h50;
  localparam int K_RX = 0, K_TXREQ = 1, K_START = 2, K_STOP = 3;
  localparam int M_IDLE = 0, M_ADDR = 1, M_WR = 2, M_RD = 3, M_IGN = 4;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       first;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic scl_prev = 1'b1;
  logic sda_prev = 1'b1;
  wire  sda_cur;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  n_txreq = 0;
  int  n_start = 0;
  int  n_rx = 0;
  logic busy_seen = 1'b0;
  logic oe_seen = 1'b0;
  int  mst = M_IDLE;
  logic first_flag = 1'b0;

  i2c_ddc_slave_ctrl_if bus ();

  i2c_ddc_slave_ctrl #(.SLAVE_ADDR(ADDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign sda_cur          = m_sda & ~bus.sda_oe;
  assign bus.scl_edge_buf = {scl_prev, m_scl};
  assign bus.sda_edge_buf = {sda_prev, sda_cur};

  // Edge-filter history: one-cycle-old sample of each open-drain line
  always @(posedge clk) begin
    scl_prev <= m_scl;
    sda_prev <= sda_cur;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] data, input logic first);
    ev_t e;
    e.kind = kind; e.data = data; e.first = first;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind, input logic [7:0] data, input logic first);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: unexpected event kind %0d data 0x%0h first %0d", kind, data, first);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data || e.first !== first) begin
        n_fail++;
        $display("FAIL scoreboard: got kind %0d data 0x%0h first %0d expected kind %0d data 0x%0h first %0d",
                 kind, data, first, e.kind, e.data, e.first);
      end
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_seen = 1'b1;
      if (bus.sda_oe) oe_seen = 1'b1;
      if (bus.bus_start) begin n_start++; sb_pop(K_START, 8'h00, 1'b0); end
      if (bus.bus_stop) sb_pop(K_STOP, 8'h00, 1'b0);
      if (bus.rx_valid) begin n_rx++; sb_pop(K_RX, bus.rx_data, bus.rx_first); end
      if (bus.tx_req) begin n_txreq++; sb_pop(K_TXREQ, 8'h00, 1'b0); end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_sda = b;
    wait_clk(4);
    m_scl = 1'b1;
    wait_clk(2);
    s = sda_cur;
    wait_clk(2);
    m_scl = 1'b0;
    wait_clk(4);
  endtask

  task automatic do_start();
    push_ev(K_START, 8'h00, 1'b0);
    m_sda = 1'b1; wait_clk(4);
    m_scl = 1'b1; wait_clk(4);
    m_sda = 1'b0; wait_clk(4);
    m_scl = 1'b0; wait_clk(4);
    mst = M_ADDR;
  endtask

  task automatic do_stop();
    push_ev(K_STOP, 8'h00, 1'b0);
    m_sda = 1'b0; wait_clk(4);
    m_scl = 1'b1; wait_clk(4);
    m_sda = 1'b1; wait_clk(4);
    mst = M_IDLE;
  endtask

  // Master writes a byte; the model predicts the ninth-clock SDA level (0 = ACK)
  task automatic wr_byte(input logic [7:0] b);
    logic exp_ack;
    logic s;
    exp_ack = 1'b1;
    if (mst == M_ADDR) begin
      if (b[7:1] == ADDR) begin
        exp_ack = 1'b0;
        if (b[0]) begin
          push_ev(K_TXREQ, 8'h00, 1'b0);
          mst = M_RD;
        end else begin
          mst = M_WR;
          first_flag = 1'b1;
        end
      end else begin
        mst = M_IGN;
      end
    end else if (mst == M_WR) begin
      push_ev(K_RX, b, first_flag);
      first_flag = 1'b0;
      exp_ack = ~bus.wr_ack_en;
    end
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    chk("ninth_bit", {31'd0, s}, {31'd0, exp_ack});
  endtask

  // Master reads a byte, then ACKs (ack=1) or NACKs; next_tx is presented for the following byte
  task automatic rd_byte(input logic [7:0] exp_b, input logic ack, input logic [7:0] next_tx);
    logic [7:0] got;
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      got[i] = s;
    end
    chk("read_byte", {24'd0, got}, {24'd0, exp_b});
    bus.tx_data = next_tx;
    if (ack) push_ev(K_TXREQ, 8'h00, 1'b0);
    send_bit(~ack, s);
    if (!ack) mst = M_IGN;
  endtask

  initial begin
    logic s;
    logic [7:0] rb [4];
    bus.tx_data = 8'h00;
    bus.wr_ack_en = 1'b1;
    wait_clk(4);
    chk("reset_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("reset_pulses", {28'd0, bus.rx_valid, bus.tx_req, bus.bus_start, bus.bus_stop}, 32'd0);
    rst = 1'b0;
    wait_clk(4);

    // Plain write with offset byte then data byte
    do_start();
    wr_byte(8'hA0);
    wr_byte(8'h00);
    wr_byte(8'h5A);
    do_stop();
    wait_clk(4);
    chk("write_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Read two bytes: ACK the first, NACK the second
    n_txreq = 0;
    bus.tx_data = 8'h96;
    do_start();
    wr_byte(8'hA1);
    rd_byte(8'h96, 1'b1, 8'hFF);
    rd_byte(8'hFF, 1'b0, 8'h00);
    chk("nack_sda_oe", {31'd0, bus.sda_oe}, 32'd0);
    chk("nack_busy", {31'd0, bus.busy}, 32'd0);
    do_stop();
    wait_clk(4);
    chk("read_txreq_count", n_txreq, 32'd2);

    // Foreign address: nothing driven, never busy
    busy_seen = 1'b0; oe_seen = 1'b0; n_rx = 0;
    do_start();
    wr_byte(8'hA2);
    wr_byte(8'h12);
    do_stop();
    wait_clk(4);
    chk("foreign_busy_seen", {31'd0, busy_seen}, 32'd0);
    chk("foreign_oe_seen", {31'd0, oe_seen}, 32'd0);
    chk("foreign_rx_count", n_rx, 32'd0);

    // Offset write, repeated START, one-byte read
    n_start = 0;
    bus.tx_data = 8'hC3;
    do_start();
    wr_byte(8'hA0);
    wr_byte(8'h10);
    do_start();
    wr_byte(8'hA1);
    rd_byte(8'hC3, 1'b0, 8'h00);
    do_stop();
    wait_clk(4);
    chk("repeated_start_count", n_start, 32'd2);

    // Data byte NACKed by the local side
    do_start();
    wr_byte(8'hA0);
    bus.wr_ack_en = 1'b0;
    wr_byte(8'h33);
    bus.wr_ack_en = 1'b1;
    do_stop();
    wait_clk(4);

    // Reset while ACKing the address
    do_start();
    for (int i = 7; i >= 0; i--) begin
      rb[0] = 8'hA0;
      send_bit(rb[0][i], s);
    end
    chk("ack_drive_before_rst", {31'd0, bus.sda_oe}, 32'd1);
    rst = 1'b1;
    wait_clk(1);
    chk("rst_release_sda", {31'd0, bus.sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    mst = M_IDLE;
    do_start();
    wr_byte(8'hA0);
    wr_byte(8'h77);
    do_stop();
    wait_clk(4);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      logic ok;
      logic rw;
      logic [6:0] a;
      int nb;
      ok = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1) == 1;
      a  = ok ? ADDR : ADDR + 7'($urandom_range(1, 127));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
      do_start();
      if (rw) begin
        bus.tx_data = rb[0];
        wr_byte({a, 1'b1});
        if (ok) begin
          for (int k = 0; k < nb; k++) rd_byte(rb[k], k < nb - 1, rb[k + 1]);
        end
      end else begin
        wr_byte({a, 1'b0});
        for (int k = 0; k < nb; k++) begin
          bus.wr_ack_en = $urandom_range(0, 1) == 1;
          wr_byte(rb[k]);
        end
        bus.wr_ack_en = 1'b1;
      end
      do_stop();
      wait_clk(4);
      chk("random_idle_busy", {31'd0, bus.busy}, 32'd0);
    end

    wait_clk(8);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
